// File: rtl/demux1_4_dispatch_if.sv
// demux1_4_dispatch_if: source and destination handshake bundle for the 1:4 result demux
//   master: source/consumer side (drives in_valid, in_data, in_sel, out_ready)
//   slave:  demux side (drives in_ready, out_valid, out_data)
interface demux1_4_dispatch_if #(parameter int W = 64);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_sel;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [4*W-1:0] out_data;
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux1_4_dispatch.sv
// demux1_4_dispatch: registered 1:4 demux steering one result stream onto four handshaked channels
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset; empties every slot and clears payloads
//   bus     slave side of demux1_4_dispatch_if (in_valid/in_ready/in_data/in_sel in,
//           out_valid/out_ready/out_data out, channel k payload at out_data[k*W +: W])
//   cnt_out per-channel 16-bit delivered-transfer counts at [k*16 +: 16],
//           present only when DEMUX_CNT_EN is defined
module demux1_4_dispatch #(parameter int W = 64) (
  input logic clk,
  input logic rst_n,
  demux1_4_dispatch_if.slave bus
`ifdef DEMUX_CNT_EN
  , output logic [63:0] cnt_out
`endif
);
  logic [3:0]   vld;
  logic [3:0]   load;
  logic [3:0]   fire;
  logic [W-1:0] dat [4];
  // Only the addressed slot gates acceptance, so a stalled channel never blocks the others.
  assign bus.in_ready = !vld[bus.in_sel] || bus.out_ready[bus.in_sel];
  assign fire = vld & bus.out_ready;
  assign load = {4{bus.in_valid && bus.in_ready}} & (4'b0001 << bus.in_sel);
  assign bus.out_valid = vld;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < 4; i++) dat[i] <= '0;
    end else begin
      // A load wins over a drain, allowing refill in the same cycle the slot empties.
      vld <= load | (vld & ~fire);
      for (int i = 0; i < 4; i++) if (load[i]) dat[i] <= bus.in_data;
    end
  end
  for (genvar g = 0; g < 4; g++) begin : g_out
    assign bus.out_data[g*W +: W] = dat[g];
  end
`ifdef DEMUX_CNT_EN
  logic [15:0] cnt [4];
  always_ff @(posedge clk) begin
    if (!rst_n) for (int i = 0; i < 4; i++) cnt[i] <= '0;
    else for (int i = 0; i < 4; i++) cnt[i] <= cnt[i] + 16'(fire[i]);
  end
  for (genvar g = 0; g < 4; g++) begin : g_cnt
    assign cnt_out[g*16 +: 16] = cnt[g];
  end
`endif
endmodule

// File: tb/tb_demux1_4_dispatch.sv
// tb_demux1_4_dispatch: directed self-checking bench for demux1_4_dispatch
module tb_demux1_4_dispatch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int errors = 0;
  demux1_4_dispatch_if bus();
`ifdef DEMUX_CNT_EN
  logic [63:0] cnt_out;
  demux1_4_dispatch dut (.clk(clk), .rst_n(rst_n), .bus(bus), .cnt_out(cnt_out));
`else
  demux1_4_dispatch dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
  always #5 clk = ~clk;

  function automatic logic [63:0] ch(input int k);
    return bus.out_data[k*64 +: 64];
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; bus.in_valid = 1'b1; bus.in_sel = 2'd2; bus.in_data = 64'hFF; bus.out_ready = 4'b0000;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    vectors++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b exp 0000", bus.out_valid); end
    vectors++; if (bus.out_data !== 256'd0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.out_data); end
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1; bus.in_data = 64'h77;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 4'b1111;
    @(negedge clk);
    vectors++; if (bus.out_valid !== 4'b0100) begin errors++; $display("FAIL post_reset_valid got %b exp 0100", bus.out_valid); end
    vectors++; if (ch(2) !== 64'h77) begin errors++; $display("FAIL post_reset_data got %h exp 77", ch(2)); end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL post_reset_drain got %b exp 0000", bus.out_valid); end
  endtask

  task automatic test_routing;
    bus.out_ready = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i < 4) begin
        bus.in_valid = 1'b1; bus.in_sel = 2'(i); bus.in_data = 64'hA0 + 64'(i);
      end else bus.in_valid = 1'b0;
      @(negedge clk);
      if (i > 0) begin
        vectors++; if (bus.out_valid !== 4'(1 << (i-1))) begin errors++; $display("FAIL route_valid ch%0d got %b exp %b", i-1, bus.out_valid, 4'(1 << (i-1))); end
        vectors++; if (ch(i-1) !== 64'hA0 + 64'(i-1)) begin errors++; $display("FAIL route_data ch%0d got %h exp %h", i-1, ch(i-1), 64'hA0 + 64'(i-1)); end
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL route_drain got %b exp 0000", bus.out_valid); end
  endtask

  task automatic test_back_pressure;
    @(posedge clk); #1;
    bus.out_ready = 4'b1011; bus.in_valid = 1'b1; bus.in_sel = 2'd2; bus.in_data = 64'h1234;
    @(negedge clk);
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready got %b exp 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_data = 64'h5678;
    @(negedge clk);
    vectors++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready got %b exp 0", bus.in_ready); end
    vectors++; if (ch(2) !== 64'h1234 || bus.out_valid[2] !== 1'b1) begin errors++; $display("FAIL bp_hold got %h/%b exp 1234/1", ch(2), bus.out_valid[2]); end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++; if (ch(2) !== 64'h1234 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_stable got %h/%b exp 1234/0", ch(2), bus.in_ready); end
    @(posedge clk); #1;
    bus.out_ready = 4'b1111;
    @(negedge clk);
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (ch(2) !== 64'h5678 || bus.out_valid !== 4'b0100) begin errors++; $display("FAIL bp_refill got %h/%b exp 5678/0100", ch(2), bus.out_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL bp_drain got %b exp 0000", bus.out_valid); end
  endtask

  task automatic test_non_blocking;
    @(posedge clk); #1;
    bus.out_ready = 4'b0000; bus.in_valid = 1'b1; bus.in_sel = 2'd1; bus.in_data = 64'h1111;
    @(posedge clk); #1;
    bus.in_sel = 2'd3; bus.in_data = 64'hBEEF;
    @(negedge clk);
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL nb_ready got %b exp 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 4'b1000; bus.in_sel = 2'd1;
    @(negedge clk);
    vectors++; if (bus.out_valid !== 4'b1010 || ch(3) !== 64'hBEEF) begin errors++; $display("FAIL nb_load got %b/%h exp 1010/beef", bus.out_valid, ch(3)); end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++; if (bus.out_valid !== 4'b0010 || ch(1) !== 64'h1111) begin errors++; $display("FAIL nb_hold got %b/%h exp 0010/1111", bus.out_valid, ch(1)); end
    vectors++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL nb_stalled_ready got %b exp 0", bus.in_ready); end
    @(posedge clk); #1;
    bus.out_ready = 4'b1111;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL nb_drain got %b exp 0000", bus.out_valid); end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    bus.out_ready = 4'b0000; bus.in_valid = 1'b1; bus.in_sel = 2'd0; bus.in_data = 64'hC0;
    @(posedge clk); #1;
    bus.in_sel = 2'd3; bus.in_data = 64'hC3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (bus.out_valid !== 4'b1001) begin errors++; $display("FAIL mid_full got %b exp 1001", bus.out_valid); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL mid_valid got %b exp 0000", bus.out_valid); end
    vectors++; if (ch(0) !== 64'd0 || ch(3) !== 64'd0) begin errors++; $display("FAIL mid_data got %h/%h exp 0/0", ch(0), ch(3)); end
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b exp 1", bus.in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1; bus.out_ready = 4'b1111;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    vectors++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL mid_no_delivery got %b exp 0000", bus.out_valid); end
  endtask

`ifdef DEMUX_CNT_EN
  task automatic test_counter;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++; if (cnt_out !== 64'd0) begin errors++; $display("FAIL cnt_reset got %h exp 0", cnt_out); end
    @(posedge clk); #1;
    rst_n = 1'b1; bus.out_ready = 4'b1111; bus.in_valid = 1'b1; bus.in_sel = 2'd0; bus.in_data = 64'h5;
    for (int i = 0; i < 65537; i++) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++; if (cnt_out !== 64'h0000_0000_0000_0001) begin errors++; $display("FAIL cnt_wrap got %h exp 0000000000000001", cnt_out); end
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0; bus.in_sel = 2'd0; bus.in_data = '0; bus.out_ready = 4'b0000;
    test_reset;
    test_routing;
    test_back_pressure;
    test_non_blocking;
    test_reset_mid;
`ifdef DEMUX_CNT_EN
    test_counter;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/demux1_4_dispatch.md
# demux1_4_dispatch

Registered 1:4 demultiplexer that steers one 64-bit ALU result stream onto one of four independent destination channels, selected per transfer by a 2-bit select. It is the distribution counterpart to the ALU's 4:1 operand/result selection tree. Each destination has its own one-entry output register with a valid/ready handshake, so one stalled consumer does not block traffic to the others once its slot is drained.

## Interface
- W, 64, data width of input and of each output channel
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  source presents a transfer
- in_ready  output  1  block accepts transfer this cycle
- in_data  input  W  payload
- in_sel  input  2  destination index, 0..3; S0 = in_sel[0] (LSB), S1 = in_sel[1] (MSB)
- out_valid  output  4  bit k: channel k register holds data
- out_ready  input  4  bit k: consumer k takes data this cycle
- out_data  output  4*W  channel k payload at bits [k*W +: W]
- cnt_out (only with DEMUX_CNT_EN)  output  4*16  channel k delivered-transfer count at bits [k*16 +: 16]

## Operation
- Input handshake fires when in_valid && in_ready; output k fires when out_valid[k] && out_ready[k].
- in_ready = !out_valid[in_sel] || out_ready[in_sel]; combinational from in_sel and out_ready, no dependence on in_valid.
- On input fire: channel in_sel loads in_data, out_valid[in_sel] <= 1 (refill in the same cycle as drain allowed).
- On output fire of k with no load to k: out_valid[k] <= 0; out_data k holds its last value.
- Channels not addressed by in_sel are unaffected by the input handshake; any number of outputs may fire in one cycle.
- in_sel is sampled only when in_valid is high; with in_valid low no channel is loaded.
- Once out_valid[k] is high, out_data k is stable until output k fires.
- Ordering preserved per channel; no ordering guarantee across channels.
- Reset (rst_n low at clock edge): out_valid = 4'b0000, out_data = 0, counters = 0. Reset mid-operation discards held data; in_ready reads 1 during and after reset (all slots empty).

## Timing
- Latency: data accepted at edge N is visible on out_data k with out_valid[k] = 1 after edge N; earliest consumer fire at edge N+1.
- Throughput: one transfer per cycle to a channel whose consumer holds out_ready high; one per cycle overall when rotating over empty channels.
- Back-pressure: channel k full and out_ready[k] low, with in_sel = k -> in_ready = 0, source must hold in_data/in_sel stable.
- No combinational path from in_valid or in_data to any output.

## Configuration
- DEMUX_CNT_EN defined: per-channel 16-bit counter increments on each output fire of that channel, wraps 16'hFFFF -> 16'h0000, cleared by reset; exposed on cnt_out.
- DEMUX_CNT_EN undefined: no counters, no cnt_out port; handshake behaviour identical.

## Test plan
- Reset: drive rst_n = 0 for 2 cycles with in_valid = 1 -> out_valid = 0000, out_data = 0, in_ready = 1; first post-reset transfer accepted normally.
- Routing: out_ready = 1111, send 64'hA0..A3 with in_sel 0,1,2,3 on consecutive cycles -> each appears on its channel exactly one cycle later, others stay invalid.
- Back-pressure: out_ready[2] = 0, send 64'h1234 then 64'h5678 to channel 2 -> first held stable, in_ready = 0 on second; raise out_ready[2] -> 64'h1234 fires, 64'h5678 accepted in the same cycle, delivered the next.
- Non-blocking: channel 1 stalled full, send 64'hBEEF to channel 3 -> accepted immediately, delivered on channel 3 while channel 1 still holds.
- Reset mid-operation: channels 0 and 3 full, assert rst_n = 0 -> both out_valid drop at that edge; held data never delivered.
- Counter wrap (DEMUX_CNT_EN): 65537 transfers on channel 0 with out_ready[0] = 1 -> cnt_out channel 0 = 1, channels 1..3 = 0.
